// File: rtl/shift_seq_ctrl.sv
// Step sequencer for an 8-bit bidirectional shift register: serially loads a pattern,
// then issues shift/rotate/ping-pong steps at a fixed tick rate while tracking a shadow image.
module shift_seq_ctrl #(
  parameter int unsigned DATA_WIDTH2 = 8,
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned TICK_W      = 27
) (
  input  logic                   i_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH2-1:0] pattern,
  input  logic [7:0]             steps,
  output logic                   o_ld,
  output logic                   o_cnt,
  output logic                   o_a_in,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [7:0]             o_step_cnt,
  output logic [DATA_WIDTH2-1:0] o_shadow
);

  localparam int unsigned W     = DATA_WIDTH2;
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH2);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [1:0]         mode_q, mode_d;
  logic [W-1:0]       load_sr_q, load_sr_d;
  logic [7:0]         steps_q, steps_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   pp_cnt_q, pp_cnt_d;
  logic               pp_dir_q, pp_dir_d;
  logic               ld_q, ld_d;
  logic               cnt_q, cnt_d;
  logic               a_in_q, a_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         step_cnt_q, step_cnt_d;
  logic [W-1:0]       shadow_q, shadow_d;

  logic               tick_wrap;
  logic [TICK_W-1:0]  tick_next;
  logic               run_right;
  logic               run_bit;

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    mode_d     = mode_q;
    load_sr_d  = load_sr_q;
    steps_d    = steps_q;
    idx_d      = idx_q;
    pp_cnt_d   = pp_cnt_q;
    pp_dir_d   = pp_dir_q;
    ld_d       = 1'b0;
    cnt_d      = cnt_q;
    a_in_d     = a_in_q;
    done_d     = 1'b0;
    step_cnt_d = step_cnt_q;
    shadow_d   = shadow_q;

    tick_wrap  = (tick_q == TICK_W'(TICK_DIV - 32'd1));
    tick_next  = tick_wrap ? '0 : tick_q + TICK_W'(1);

    run_right  = 1'b0;
    run_bit    = 1'b0;
    case (mode_q)
      2'b00:   run_right = 1'b0;
      2'b01:   run_right = 1'b1;
      2'b10:   run_bit   = shadow_q[W-1];
      default: begin
        run_right = pp_dir_q;
        run_bit   = pp_dir_q ? shadow_q[0] : shadow_q[W-1];
      end
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d     = mode;
          load_sr_d  = pattern;
          steps_d    = steps;
          tick_d     = '0;
          step_cnt_d = '0;
          shadow_d   = '0;
          idx_d      = '0;
          pp_cnt_d   = '0;
          pp_dir_d   = 1'b0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          tick_d = tick_next;
          if (tick_wrap) begin
            ld_d      = 1'b1;
            cnt_d     = 1'b0;
            a_in_d    = load_sr_q[W-1];
            shadow_d  = {shadow_q[W-2:0], load_sr_q[W-1]};
            load_sr_d = {load_sr_q[W-2:0], 1'b0};
            idx_d     = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(W - 32'd1)) state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (steps_q != 8'd0 && step_cnt_q == steps_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          tick_d = tick_next;
          if (tick_wrap) begin
            ld_d       = 1'b1;
            cnt_d      = run_right;
            a_in_d     = run_bit;
            shadow_d   = run_right ? {run_bit, shadow_q[W-1:1]}
                                   : {shadow_q[W-2:0], run_bit};
            step_cnt_d = step_cnt_q + 8'd1;
            // Ping-pong flips direction after every W-1 steps
            if (mode_q == 2'b11) begin
              if (pp_cnt_q == IDX_W'(W - 32'd2)) begin
                pp_cnt_d = '0;
                pp_dir_d = ~pp_dir_q;
              end else begin
                pp_cnt_d = pp_cnt_q + IDX_W'(1);
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      mode_q     <= '0;
      load_sr_q  <= '0;
      steps_q    <= '0;
      idx_q      <= '0;
      pp_cnt_q   <= '0;
      pp_dir_q   <= 1'b0;
      ld_q       <= 1'b0;
      cnt_q      <= 1'b0;
      a_in_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_cnt_q <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      mode_q     <= mode_d;
      load_sr_q  <= load_sr_d;
      steps_q    <= steps_d;
      idx_q      <= idx_d;
      pp_cnt_q   <= pp_cnt_d;
      pp_dir_q   <= pp_dir_d;
      ld_q       <= ld_d;
      cnt_q      <= cnt_d;
      a_in_q     <= a_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_cnt_q <= step_cnt_d;
      shadow_q   <= shadow_d;
    end
  end

  assign o_ld       = ld_q;
  assign o_cnt      = cnt_q;
  assign o_a_in     = a_in_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_step_cnt = step_cnt_q;
  assign o_shadow   = shadow_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: cycle-count based reference model plus
// directed scenarios with literal expectations and randomized commands.
module tb_shift_seq_ctrl;

  localparam int W  = 8;
  localparam int TD = 4;

  logic       i_clk = 1'b0;
  logic       rst, start, stop;
  logic [1:0] mode;
  logic [7:0] pattern, steps;
  logic       o_ld, o_cnt, o_a_in, o_busy, o_done;
  logic [7:0] o_step_cnt, o_shadow;

  int n_cmp  = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.DATA_WIDTH2(8), .TICK_DIV(TD), .TICK_W(3)) dut (
    .i_clk(i_clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .pattern(pattern), .steps(steps), .o_ld(o_ld), .o_cnt(o_cnt),
    .o_a_in(o_a_in), .o_busy(o_busy), .o_done(o_done),
    .o_step_cnt(o_step_cnt), .o_shadow(o_shadow)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: outputs after p pulses, replayed from the command itself
  function automatic void replay(input int p, input logic [1:0] md, input logic [7:0] pat,
                                 output logic [7:0] sh, output logic c, output logic a);
    sh = 8'h00; c = 1'b0; a = 1'b0;
    for (int i = 1; i <= p; i++) begin
      if (i <= W) begin
        c = 1'b0;
        a = pat[W-i];
      end else begin
        case (md)
          2'b00:   begin c = 1'b0; a = 1'b0; end
          2'b01:   begin c = 1'b1; a = 1'b0; end
          2'b10:   begin c = 1'b0; a = sh[7]; end
          default: begin
            c = (((i - W - 1) / (W - 1)) % 2) == 1;
            a = c ? sh[0] : sh[7];
          end
        endcase
      end
      sh = c ? {a, sh[7:1]} : {sh[6:0], a};
    end
  endfunction

  logic       m_busy, m_ld, m_done, m_cnt, m_ain;
  logic [7:0] m_shadow, m_stepcnt, m_steps, m_pat;
  logic [1:0] m_md;
  int         m_k;
  int         k_n, total, p;
  logic [7:0] r_sh;
  logic       r_c, r_a;

  // Model: edges counted since the start edge decide pulses, completion and busy
  always @(posedge i_clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_ld <= 0; m_done <= 0; m_cnt <= 0; m_ain <= 0;
      m_shadow <= 0; m_stepcnt <= 0; m_k <= 0; m_md <= 0; m_pat <= 0; m_steps <= 0;
    end else begin
      m_ld <= 0;
      m_done <= 0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1; m_k <= 0; m_md <= mode; m_pat <= pattern; m_steps <= steps;
          m_shadow <= 0; m_stepcnt <= 0;
        end
      end else if (stop) begin
        m_busy <= 0;
      end else begin
        k_n = m_k + 1;
        m_k <= k_n;
        total = W + int'(m_steps);
        if (m_steps != 0 && k_n == total * TD + 1) begin
          m_busy <= 0;
          m_done <= 1;
        end else if (k_n % TD == 0) begin
          p = k_n / TD;
          replay(p, m_md, m_pat, r_sh, r_c, r_a);
          m_ld <= 1; m_shadow <= r_sh; m_cnt <= r_c; m_ain <= r_a;
          m_stepcnt <= (p > W) ? 8'(p - W) : 8'd0;
        end
      end
    end
  end

  // Every-cycle compare against the model
  always @(negedge i_clk) begin
    chk("o_ld", 32'(o_ld), 32'(m_ld));
    chk("o_cnt", 32'(o_cnt), 32'(m_cnt));
    chk("o_a_in", 32'(o_a_in), 32'(m_ain));
    chk("o_busy", 32'(o_busy), 32'(m_busy));
    chk("o_done", 32'(o_done), 32'(m_done));
    chk("o_step_cnt", 32'(o_step_cnt), 32'(m_stepcnt));
    chk("o_shadow", 32'(o_shadow), 32'(m_shadow));
  end

  // Pulse monitor for the directed literal checks
  int         cyc = 0, done_n = 0, done_cyc = 0, rise_cyc = 0;
  logic       busy_prev = 1'b0;
  int         ld_cyc[$];
  logic       ld_c[$];
  logic       ld_a[$];
  logic [7:0] ld_sh[$];

  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_ld === 1'b1) begin
      ld_cyc.push_back(cyc); ld_c.push_back(o_cnt);
      ld_a.push_back(o_a_in); ld_sh.push_back(o_shadow);
    end
    if (o_done === 1'b1) begin done_n <= done_n + 1; done_cyc <= cyc; end
    if (o_busy === 1'b1 && !busy_prev) rise_cyc <= cyc;
    busy_prev <= (o_busy === 1'b1);
  end

  task automatic step_clk();
    @(negedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    ld_cyc.delete(); ld_c.delete(); ld_a.delete(); ld_sh.delete();
    done_n = 0;
  endtask

  task automatic start_cmd(input logic [1:0] m, input logic [7:0] pt, input logic [7:0] s);
    clear_mon();
    mode = m; pattern = pt; steps = s; start = 1'b1;
    step_clk();
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int c = 0;
    while (ld_cyc.size() < n && c < budget) begin step_clk(); c++; end
    chk("wait_pulses", 32'(ld_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (o_busy === 1'b1 && c < budget) begin step_clk(); c++; end
    chk("wait_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic chk_spacing();
    if (ld_cyc.size() > 0) begin
      chk("first_latency", 32'(ld_cyc[0] - rise_cyc), 32'(TD));
      for (int i = 1; i < ld_cyc.size(); i++)
        chk("pulse_spacing", 32'(ld_cyc[i] - ld_cyc[i-1]), 32'(TD));
    end
  endtask

  initial begin
    logic [7:0] a5_seq;
    int         c, s, stop_at, budget;
    rst = 0; start = 0; stop = 0; mode = 0; pattern = 0; steps = 0;
    #2 rst = 1;
    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_shadow", 32'(o_shadow), 32'd0);
    chk("rst_step_cnt", 32'(o_step_cnt), 32'd0);
    repeat (3) step_clk();
    rst = 0;
    step_clk();

    // Asynchronous reset mid-LOAD, start ignored while held
    start_cmd(2'b00, 8'hFF, 8'd0);
    wait_pulses(3, 40);
    chk("pre_rst_shadow", 32'(o_shadow), 32'h07);
    @(posedge i_clk);
    #2 rst = 1;
    #1;
    chk("async_busy", 32'(o_busy), 32'd0);
    chk("async_shadow", 32'(o_shadow), 32'd0);
    chk("async_ld", 32'(o_ld), 32'd0);
    start = 1;
    repeat (3) step_clk();
    chk("rst_hold_busy", 32'(o_busy), 32'd0);
    start = 0; rst = 0;
    step_clk();

    // Shift left 0xA5, 3 steps
    start_cmd(2'b00, 8'hA5, 8'd3);
    wait_idle(80);
    step_clk();
    a5_seq = 8'b1010_0101;
    chk("sl_pulses", 32'(ld_cyc.size()), 32'd11);
    if (ld_cyc.size() == 11) begin
      for (int i = 0; i < 8; i++) begin
        chk("sl_load_ain", 32'(ld_a[i]), 32'(a5_seq[7-i]));
        chk("sl_load_cnt", 32'(ld_c[i]), 32'd0);
      end
      for (int i = 8; i < 11; i++) chk("sl_run_ain", 32'(ld_a[i]), 32'd0);
      chk("sl_after_load", 32'(ld_sh[7]), 32'hA5);
      chk("sl_done_timing", 32'(done_cyc), 32'(ld_cyc[10] + 1));
    end
    chk_spacing();
    chk("sl_shadow", 32'(o_shadow), 32'h28);
    chk("sl_step_cnt", 32'(o_step_cnt), 32'd3);
    chk("sl_done_n", 32'(done_n), 32'd1);

    // Rotate left 0x81, 1 step
    start_cmd(2'b10, 8'h81, 8'd1);
    wait_idle(60);
    chk("rl_pulses", 32'(ld_cyc.size()), 32'd9);
    if (ld_cyc.size() == 9) chk("rl_ain", 32'(ld_a[8]), 32'd1);
    chk("rl_shadow", 32'(o_shadow), 32'h03);
    chk("rl_step_cnt", 32'(o_step_cnt), 32'd1);

    // Continuous shift right, abort after 7 run steps
    start_cmd(2'b01, 8'h80, 8'd0);
    wait_pulses(15, 100);
    stop = 1;
    step_clk();
    stop = 0;
    repeat (10) step_clk();
    chk("sr_shadow", 32'(o_shadow), 32'h01);
    chk("sr_busy", 32'(o_busy), 32'd0);
    chk("sr_done_n", 32'(done_n), 32'd0);
    chk("sr_pulses", 32'(ld_cyc.size()), 32'd15);
    chk("sr_step_cnt", 32'(o_step_cnt), 32'd7);

    // Ping-pong 0x01, 14 steps, then restart on the done cycle
    start_cmd(2'b11, 8'h01, 8'd14);
    c = 0;
    while (o_done !== 1'b1 && c < 150) begin step_clk(); c++; end
    chk("pp_done", 32'(o_done), 32'd1);
    chk("pp_pulses", 32'(ld_cyc.size()), 32'd22);
    if (ld_cyc.size() == 22) begin
      chk("pp_mid_shadow", 32'(ld_sh[14]), 32'h80);
      for (int i = 8; i < 22; i++) chk("pp_dir", 32'(ld_c[i]), 32'(i >= 15));
    end
    chk("pp_shadow", 32'(o_shadow), 32'h01);
    start_cmd(2'b00, 8'h3C, 8'd1);
    chk("start_on_done", 32'(o_busy), 32'd1);
    wait_idle(60);
    chk("sod_shadow", 32'(o_shadow), 32'h78);

    // Start while busy is ignored
    start_cmd(2'b00, 8'hF0, 8'd2);
    wait_pulses(3, 40);
    mode = 2'b01; pattern = 8'h0F; steps = 8'd5; start = 1;
    step_clk();
    start = 0;
    wait_idle(80);
    chk("ign_shadow", 32'(o_shadow), 32'hC0);
    chk("ign_step_cnt", 32'(o_step_cnt), 32'd2);
    chk("ign_pulses", 32'(ld_cyc.size()), 32'd10);

    // Stop coinciding with a tick suppresses the pulse
    start_cmd(2'b01, 8'hFF, 8'd0);
    wait_pulses(10, 60);
    repeat (3) step_clk();
    stop = 1;
    step_clk();
    stop = 0;
    repeat (6) step_clk();
    chk("col_pulses", 32'(ld_cyc.size()), 32'd10);
    chk("col_busy", 32'(o_busy), 32'd0);
    chk("col_shadow", 32'(o_shadow), 32'h3F);
    chk("col_step_cnt", 32'(o_step_cnt), 32'd2);

    // Reset during RUN, then a clean restart
    start_cmd(2'b10, 8'h55, 8'd0);
    wait_pulses(10, 60);
    #2 rst = 1;
    #1 chk("run_rst_busy", 32'(o_busy), 32'd0);
    step_clk();
    rst = 0;
    step_clk();
    start_cmd(2'b10, 8'h81, 8'd1);
    wait_idle(60);
    chk("restart_shadow", 32'(o_shadow), 32'h03);
    chk("restart_pulses", 32'(ld_cyc.size()), 32'd9);
    chk_spacing();

    // Randomized commands with stray starts and aborts
    for (int it = 0; it < 14; it++) begin
      s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
      start_cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'(s));
      if (s == 0) stop_at = int'($urandom_range(20, 160));
      else if ($urandom_range(0, 2) == 0) stop_at = int'($urandom_range(1, (8 + s) * TD));
      else stop_at = -1;
      budget = (s == 0) ? stop_at + 10 : (8 + s) * TD + 10;
      for (int k = 0; k < budget; k++) begin
        step_clk();
        if (o_busy !== 1'b1) break;
        start   = ($urandom_range(0, 15) == 0);
        mode    = 2'($urandom_range(0, 3));
        pattern = 8'($urandom_range(0, 255));
        steps   = 8'($urandom_range(0, 20));
        stop    = (k == stop_at);
      end
      start = 0; stop = 0;
      chk("rand_idle", 32'(o_busy), 32'd0);
      stop = ($urandom_range(0, 1) == 1);
      repeat (2) step_clk();
      stop = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
